// File: rtl/rs232_ser.sv
// RS-232 8N1 transmitter: takes bytes over a req/ack handshake and shifts them out LSB first.
// Define RS232_SER_PARITY_EN to insert an even-parity bit between data bit 7 and the stop bit.
module rs232_ser #(
   parameter int P_CLK_FREQ_HZ = 100000000,
   parameter int P_BAUD_RATE   = 9600
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] tx_data,
   input  logic       tx_req,
   output logic       tx_ack,
   output logic       tx,
   output logic       busy
);

   function automatic int clogb2(input int value);
      int v;
      int r;
      v = value - 1;
      for (r = 0; v > 0; r++) begin
         v = v >> 1;
      end
      return r;
   endfunction

   localparam int BIT_CNT_MAX = P_CLK_FREQ_HZ / P_BAUD_RATE;
   localparam int CNT_W       = clogb2(BIT_CNT_MAX);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIT_CNT_MAX - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_SHIFT,
`ifdef RS232_SER_PARITY_EN
      S_PARITY,
`endif
      S_STOP
   } state_t;

   state_t           state;
   logic [CNT_W-1:0] bit_cnt;
   logic [2:0]       shift_cnt;
   logic [7:0]       shift_reg;
   logic             bit_done;
`ifdef RS232_SER_PARITY_EN
   logic             parity;
`endif

   assign bit_done = (bit_cnt == CNT_LAST);

   // Each state drives tx one cycle ahead so the line is registered and glitch-free.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_IDLE;
         bit_cnt   <= '0;
         shift_cnt <= 3'd0;
         shift_reg <= 8'h00;
         tx        <= 1'b1;
         tx_ack    <= 1'b0;
         busy      <= 1'b0;
`ifdef RS232_SER_PARITY_EN
         parity    <= 1'b0;
`endif
      end else begin
         tx_ack <= 1'b0;
         if (state != S_IDLE) begin
            bit_cnt <= bit_done ? '0 : bit_cnt + 1'b1;
         end
         case (state)
            S_IDLE: begin
               tx   <= 1'b1;
               busy <= 1'b0;
               if (tx_req) begin
                  shift_reg <= tx_data;
`ifdef RS232_SER_PARITY_EN
                  parity    <= ^tx_data;
`endif
                  tx_ack    <= 1'b1;
                  tx        <= 1'b0;
                  busy      <= 1'b1;
                  bit_cnt   <= '0;
                  shift_cnt <= 3'd0;
                  state     <= S_START;
               end
            end
            S_START: begin
               if (bit_done) begin
                  tx    <= shift_reg[0];
                  state <= S_SHIFT;
               end
            end
            S_SHIFT: begin
               if (bit_done) begin
                  shift_reg <= shift_reg >> 1;
                  shift_cnt <= shift_cnt + 3'd1;
                  if (shift_cnt == 3'd7) begin
`ifdef RS232_SER_PARITY_EN
                     tx    <= parity;
                     state <= S_PARITY;
`else
                     tx    <= 1'b1;
                     state <= S_STOP;
`endif
                  end else begin
                     tx <= shift_reg[1];
                  end
               end
            end
`ifdef RS232_SER_PARITY_EN
            S_PARITY: begin
               if (bit_done) begin
                  tx    <= 1'b1;
                  state <= S_STOP;
               end
            end
`endif
            S_STOP: begin
               if (bit_done) begin
                  tx    <= 1'b1;
                  busy  <= 1'b0;
                  state <= S_IDLE;
               end
            end
            default: begin
               tx    <= 1'b1;
               busy  <= 1'b0;
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_rs232_ser.sv
// Self-checking bench for rs232_ser: directed handshake/reset cases plus random bytes,
// each line cycle compared against a bit-index model of the frame.
module tb_rs232_ser;

   localparam int P = 10;
`ifdef RS232_SER_PARITY_EN
   localparam int NBITS = 11;
`else
   localparam int NBITS = 10;
`endif
   localparam int FRAME = NBITS * P;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] tx_data;
   logic       tx_req;
   logic       tx_ack;
   logic       tx;
   logic       busy;

   int vectors     = 0;
   int miscompares = 0;

   rs232_ser #(
      .P_CLK_FREQ_HZ(1000),
      .P_BAUD_RATE  (100)
   ) dut (
      .clk    (clk),
      .rst    (rst),
      .tx_data(tx_data),
      .tx_req (tx_req),
      .tx_ack (tx_ack),
      .tx     (tx),
      .busy   (busy)
   );

   always #5 clk = ~clk;

   // Expected line level k cycles into a frame: start, 8 data LSB first, optional parity, stop.
   function automatic logic expBit(input logic [7:0] d, input int k);
      int idx;
      idx = k / P;
      if (idx == 0) return 1'b0;
      if (idx <= 8) return d[idx-1];
`ifdef RS232_SER_PARITY_EN
      if (idx == 9) return ^d;
`endif
      return 1'b1;
   endfunction

   task automatic checkOutput(input string tag, input logic [7:0] actual, input logic [7:0] expected);
      vectors++;
      if (actual !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, actual, expected, $time);
      end
   endtask

   task automatic idleCycles(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         checkOutput("idle_tx", 8'(tx), 8'd1);
         checkOutput("idle_busy", 8'(busy), 8'd0);
         checkOutput("idle_ack", 8'(tx_ack), 8'd0);
      end
   endtask

   // Request one byte, then follow the whole frame cycle by cycle; abort_at >= 0 resets mid-frame.
   task automatic applyStimulus(input logic [7:0] d, input bit keep_req, input bit change_data,
                                input int abort_at);
      int wait_cycles;
      wait_cycles = 0;
      tx_data = d;
      tx_req  = 1'b1;
      do begin
         @(negedge clk);
         wait_cycles++;
      end while (tx_ack !== 1'b1 && wait_cycles < 5);
      checkOutput("ack_latency", wait_cycles[7:0], 8'd1);
      if (!keep_req) tx_req = 1'b0;
      for (int k = 0; k < FRAME; k++) begin
         if (k > 0) @(negedge clk);
         if (change_data && k == 1) tx_data = ~d;
         checkOutput("frame_tx", 8'(tx), 8'(expBit(d, k)));
         checkOutput("frame_busy", 8'(busy), 8'd1);
         checkOutput("frame_ack", 8'(tx_ack), 8'(k == 0));
         if (k == abort_at) begin
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
            checkOutput("abort_tx", 8'(tx), 8'd1);
            checkOutput("abort_busy", 8'(busy), 8'd0);
            checkOutput("abort_ack", 8'(tx_ack), 8'd0);
            idleCycles(2 * P);
            return;
         end
      end
      @(negedge clk);
      checkOutput("gap_tx", 8'(tx), 8'd1);
      checkOutput("gap_busy", 8'(busy), 8'd0);
      checkOutput("gap_ack", 8'(tx_ack), 8'd0);
   endtask

   initial begin
      rst     = 1'b1;
      tx_req  = 1'b1;
      tx_data = 8'h5A;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checkOutput("reset_tx", 8'(tx), 8'd1);
         checkOutput("reset_busy", 8'(busy), 8'd0);
         checkOutput("reset_ack", 8'(tx_ack), 8'd0);
      end
      rst = 1'b0;
      applyStimulus(8'h5A, 1'b0, 1'b0, -1);
      idleCycles(2);

      applyStimulus(8'hA5, 1'b0, 1'b0, -1);
      idleCycles(3);

      applyStimulus(8'h00, 1'b1, 1'b0, -1);
      applyStimulus(8'hFF, 1'b0, 1'b0, -1);
      idleCycles(2);

      applyStimulus(8'hFF, 1'b0, 1'b0, 45);

      applyStimulus(8'h3C, 1'b0, 1'b1, -1);
      idleCycles(1);
      applyStimulus(8'h07, 1'b0, 1'b0, -1);
      applyStimulus(8'h03, 1'b0, 1'b0, -1);
      idleCycles(1);

      for (int i = 0; i < 8; i++) begin
         logic [7:0] d;
         bit         keep;
         d    = 8'($urandom);
         keep = 1'($urandom_range(0, 1)) && (i < 7);
         applyStimulus(d, keep, 1'($urandom_range(0, 1)), -1);
         if (!keep) idleCycles($urandom_range(0, 3));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
